// File: rtl/mem_stage_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_access_if #(
    parameter int unsigned DATA_W = 16
);
    logic              mem_en;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_access.sv
// Memory stage: consumes EX/MEM fields, runs a req/ack access to a multi-cycle data memory,
// stalls upstream while waiting and registers results toward MEM/WB.
module mem_stage_access #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemtoReg,
    input  logic              RegWrite,
    input  logic              HLT,
    input  logic [3:0]        dst_reg,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] ReadValue,
    input  logic [DATA_W-1:0] LBOut,
    input  logic [DATA_W-1:0] pc_out,
    mem_stage_access_if.master mem,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_HLT,
    output logic [1:0]        wb_MemtoReg,
    output logic [3:0]        wb_dst_reg,
    output logic [DATA_W-1:0] wb_ALUOut,
    output logic [DATA_W-1:0] wb_MemData,
    output logic [DATA_W-1:0] wb_LBOut,
    output logic [DATA_W-1:0] wb_pc,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StWait, StError} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    // Request fields captured when the access is issued
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_memtoreg_q, req_memtoreg_d;
    logic              req_regwrite_q, req_regwrite_d;
    logic              req_hlt_q, req_hlt_d;
    logic [3:0]        req_dst_q, req_dst_d;
    logic [DATA_W-1:0] req_alu_q, req_alu_d;
    logic [DATA_W-1:0] req_lb_q, req_lb_d;
    logic [DATA_W-1:0] req_pc_q, req_pc_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_hlt_q, wb_hlt_d;
    logic [1:0]        wb_memtoreg_q, wb_memtoreg_d;
    logic [3:0]        wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [DATA_W-1:0] wb_mdata_q, wb_mdata_d;
    logic [DATA_W-1:0] wb_lb_q, wb_lb_d;
    logic [DATA_W-1:0] wb_pc_q, wb_pc_d;

    logic              mem_op;
    logic              mem_en_c;
    logic              mem_wr_c;
    logic [DATA_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              stall_c;

    assign mem_op = in_valid & (MemRead | MemWrite);

    // Next-state, request strobe and writeback selection
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        req_wr_d       = req_wr_q;
        req_memtoreg_d = req_memtoreg_q;
        req_regwrite_d = req_regwrite_q;
        req_hlt_d      = req_hlt_q;
        req_dst_d      = req_dst_q;
        req_alu_d      = req_alu_q;
        req_lb_d       = req_lb_q;
        req_pc_d       = req_pc_q;
        // Default is a bubble: control bits drop, data fields hold
        wb_valid_d     = 1'b0;
        wb_regwrite_d  = 1'b0;
        wb_hlt_d       = 1'b0;
        wb_memtoreg_d  = wb_memtoreg_q;
        wb_dst_d       = wb_dst_q;
        wb_alu_d       = wb_alu_q;
        wb_mdata_d     = wb_mdata_q;
        wb_lb_d        = wb_lb_q;
        wb_pc_d        = wb_pc_q;
        mem_en_c       = 1'b0;
        mem_wr_c       = 1'b0;
        mem_addr_c     = '0;
        mem_wdata_c    = '0;
        stall_c        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    mem_en_c       = 1'b1;
                    mem_wr_c       = MemWrite;
                    mem_addr_c     = ALUOut;
                    mem_wdata_c    = ReadValue;
                    stall_c        = 1'b1;
                    state_d        = StWait;
                    cnt_d          = '0;
                    req_wr_d       = MemWrite;
                    req_memtoreg_d = MemtoReg;
                    req_regwrite_d = RegWrite;
                    req_hlt_d      = HLT;
                    req_dst_d      = dst_reg;
                    req_alu_d      = ALUOut;
                    req_lb_d       = LBOut;
                    req_pc_d       = pc_out;
                end else begin
                    wb_valid_d    = in_valid;
                    wb_regwrite_d = in_valid & RegWrite;
                    wb_hlt_d      = in_valid & HLT;
                    wb_memtoreg_d = MemtoReg;
                    wb_dst_d      = dst_reg;
                    wb_alu_d      = ALUOut;
                    wb_mdata_d    = '0;
                    wb_lb_d       = LBOut;
                    wb_pc_d       = pc_out;
                end
            end
            StWait: begin
                if (mem.mem_ack) begin
                    // Ack beats a same-cycle timeout
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = req_regwrite_q;
                    wb_hlt_d      = req_hlt_q;
                    wb_memtoreg_d = req_memtoreg_q;
                    wb_dst_d      = req_dst_q;
                    wb_alu_d      = req_alu_q;
                    wb_mdata_d    = req_wr_q ? '0 : mem.mem_rdata;
                    wb_lb_d       = req_lb_q;
                    wb_pc_d       = req_pc_q;
                    state_d       = StIdle;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == CntMax) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end
                end
            end
            StError: begin
                stall_c = 1'b1;
                err_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, request latch and MEM/WB registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            req_wr_q       <= 1'b0;
            req_memtoreg_q <= '0;
            req_regwrite_q <= 1'b0;
            req_hlt_q      <= 1'b0;
            req_dst_q      <= '0;
            req_alu_q      <= '0;
            req_lb_q       <= '0;
            req_pc_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_hlt_q       <= 1'b0;
            wb_memtoreg_q  <= '0;
            wb_dst_q       <= '0;
            wb_alu_q       <= '0;
            wb_mdata_q     <= '0;
            wb_lb_q        <= '0;
            wb_pc_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            req_wr_q       <= req_wr_d;
            req_memtoreg_q <= req_memtoreg_d;
            req_regwrite_q <= req_regwrite_d;
            req_hlt_q      <= req_hlt_d;
            req_dst_q      <= req_dst_d;
            req_alu_q      <= req_alu_d;
            req_lb_q       <= req_lb_d;
            req_pc_q       <= req_pc_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_hlt_q       <= wb_hlt_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_dst_q       <= wb_dst_d;
            wb_alu_q       <= wb_alu_d;
            wb_mdata_q     <= wb_mdata_d;
            wb_lb_q        <= wb_lb_d;
            wb_pc_q        <= wb_pc_d;
        end
    end

    // Combinational outputs are forced low while reset is held, even if EX/MEM shows a memory op
    assign mem.mem_en    = rst & mem_en_c;
    assign mem.mem_wr    = rst & mem_wr_c;
    assign mem.mem_addr  = rst ? mem_addr_c : '0;
    assign mem.mem_wdata = rst ? mem_wdata_c : '0;
    assign stall         = rst & stall_c;

    assign err         = err_q;
    assign wb_valid    = wb_valid_q;
    assign wb_RegWrite = wb_regwrite_q;
    assign wb_HLT      = wb_hlt_q;
    assign wb_MemtoReg = wb_memtoreg_q;
    assign wb_dst_reg  = wb_dst_q;
    assign wb_ALUOut   = wb_alu_q;
    assign wb_MemData  = wb_mdata_q;
    assign wb_LBOut    = wb_lb_q;
    assign wb_pc       = wb_pc_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access with request and writeback scoreboards.
module tb_mem_stage_access;

    localparam int unsigned DW = 16;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          hlt;
        logic [1:0]    memtoreg;
        logic [3:0]    dst;
        logic [DW-1:0] alu;
        logic [DW-1:0] mdata;
        logic [DW-1:0] lb;
        logic [DW-1:0] pc;
    } wb_t;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, MemRead, MemWrite, RegWrite, HLT;
    logic [1:0]    MemtoReg;
    logic [3:0]    dst_reg;
    logic [DW-1:0] ALUOut, ReadValue, LBOut, pc_out;
    logic          stall, err;
    logic          wb_valid, wb_RegWrite, wb_HLT;
    logic [1:0]    wb_MemtoReg;
    logic [3:0]    wb_dst_reg;
    logic [DW-1:0] wb_ALUOut, wb_MemData, wb_LBOut, wb_pc;

    mem_stage_access_if #(.DATA_W(DW)) mem_bus ();

    mem_stage_access #(.DATA_W(DW), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .HLT        (HLT),
        .dst_reg    (dst_reg),
        .ALUOut     (ALUOut),
        .ReadValue  (ReadValue),
        .LBOut      (LBOut),
        .pc_out     (pc_out),
        .mem        (mem_bus.master),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_RegWrite(wb_RegWrite),
        .wb_HLT     (wb_HLT),
        .wb_MemtoReg(wb_MemtoReg),
        .wb_dst_reg (wb_dst_reg),
        .wb_ALUOut  (wb_ALUOut),
        .wb_MemData (wb_MemData),
        .wb_LBOut   (wb_LBOut),
        .wb_pc      (wb_pc),
        .err        (err)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    int   stall_cnt = 0;
    wb_t  wb_q[$];
    req_t req_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Writeback monitor: every valid MEM/WB output must match the oldest expected entry
    always @(negedge clk) begin
        if (wb_valid) begin
            wb_t act;
            act = '{wb_valid, wb_RegWrite, wb_HLT, wb_MemtoReg, wb_dst_reg,
                    wb_ALUOut, wb_MemData, wb_LBOut, wb_pc};
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 128'(act), 128'(0));
            end else begin
                chk("wb_fields", 128'(act), 128'(wb_q.pop_front()));
            end
        end
    end

    // Request monitor: every mem_en pulse must match the oldest expected request
    always @(negedge clk) begin
        if (mem_bus.mem_en) begin
            req_t act;
            act = '{mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata};
            if (req_q.size() == 0) begin
                chk("req_unexpected", 128'(act), 128'(0));
            end else begin
                chk("req_fields", 128'(act), 128'(req_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (stall) stall_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 2'd0;
        RegWrite  = 1'b0;
        HLT       = 1'b0;
        dst_reg   = 4'd0;
        ALUOut    = 16'h0BAD;
        ReadValue = 16'h0000;
        LBOut     = 16'h0000;
        pc_out    = 16'h0000;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
    endtask

    task automatic alu_op(input logic [DW-1:0] alu, input logic [3:0] dst, input logic rw,
                          input logic [1:0] m2r, input logic [DW-1:0] lb, input logic [DW-1:0] pc);
        in_valid = 1'b1;
        RegWrite = rw;
        MemtoReg = m2r;
        dst_reg  = dst;
        ALUOut   = alu;
        LBOut    = lb;
        pc_out   = pc;
        wb_q.push_back('{1'b1, rw, 1'b0, m2r, dst, alu, 16'h0000, lb, pc});
        @(negedge clk);
        chk("alu_stall_mem_en", {126'd0, stall, mem_bus.mem_en}, 128'd0);
        tick();
        clear_inputs();
    endtask

    // Issue a memory op, let nwait WAIT cycles pass without ack, then ack
    task automatic mem_access(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] rdata, input int nwait, input logic [3:0] dst,
                              input logic rw, input logic [1:0] m2r, input logic [DW-1:0] lb,
                              input logic [DW-1:0] pc, input logic [DW-1:0] hold_alu,
                              input logic early_ack);
        int s0;
        in_valid  = 1'b1;
        MemRead   = ~wr;
        MemWrite  = wr;
        RegWrite  = rw;
        MemtoReg  = m2r;
        dst_reg   = dst;
        ALUOut    = addr;
        ReadValue = wdata;
        LBOut     = lb;
        pc_out    = pc;
        mem_bus.mem_ack   = early_ack;
        mem_bus.mem_rdata = 16'hDEAD;
        req_q.push_back('{wr, addr, wdata});
        wb_q.push_back('{1'b1, rw, 1'b0, m2r, dst, addr, (wr ? 16'h0000 : rdata), lb, pc});
        s0 = stall_cnt;
        @(negedge clk);
        chk("mem_en_issue", {126'd0, mem_bus.mem_en, stall}, 128'd3);
        tick();
        mem_bus.mem_ack = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("wait_bubble_hold", {109'd0, wb_valid, wb_RegWrite, wb_HLT, wb_ALUOut},
                    {109'd0, 3'b000, hold_alu});
            end
            tick();
        end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = rdata;
        tick();
        chk("stall_cycles", 128'(stall_cnt - s0), 128'(1 + nwait));
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        // Reset with a load sitting on EX/MEM: outputs must stay quiet
        rst      = 1'b0;
        in_valid = 1'b1;
        MemRead  = 1'b1;
        ALUOut   = 16'h7777;
        #2;
        @(negedge clk);
        chk("reset_mem_en_stall_err", {125'd0, mem_bus.mem_en, stall, err}, 128'd0);
        chk("reset_mem_bus", {96'd0, mem_bus.mem_addr, mem_bus.mem_wdata}, 128'd0);
        chk("reset_wb", {54'd0, wb_valid, wb_RegWrite, wb_HLT, wb_MemtoReg, wb_dst_reg,
                         wb_ALUOut, wb_MemData, wb_LBOut, wb_pc}, 128'd0);
        clear_inputs();
        #2 rst = 1'b1;
        tick();

        // 1: ALU op
        alu_op(16'h1234, 4'd5, 1'b1, 2'd0, 16'h00F0, 16'h0100);
        tick();

        // 2: load, three silent WAIT cycles, then ack with BEEF
        mem_access(1'b0, 16'h0040, 16'h1111, 16'hBEEF, 3, 4'd3, 1'b1, 2'd1, 16'h0022, 16'h0104,
                   16'h0BAD, 1'b0);
        tick();

        // 3: store, ack held during the issue cycle (ignored), one silent WAIT, then ack
        mem_access(1'b1, 16'h0010, 16'hA5A5, 16'h5555, 1, 4'd7, 1'b0, 2'd0, 16'h0033, 16'h0108,
                   16'h0BAD, 1'b1);
        tick();

        // 5: spurious ack in IDLE together with a bubble carrying RegWrite/HLT
        in_valid = 1'b0;
        RegWrite = 1'b1;
        HLT      = 1'b1;
        MemRead  = 1'b1;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'hFFFF;
        @(negedge clk);
        chk("bubble_no_req", {126'd0, mem_bus.mem_en, stall}, 128'd0);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("bubble_wb", {109'd0, wb_valid, wb_RegWrite, wb_HLT, wb_MemData}, 128'd0);
        tick();

        // 6: back-to-back loads, each acked after one silent WAIT cycle
        mem_access(1'b0, 16'h0200, 16'h0000, 16'h1357, 1, 4'd1, 1'b1, 2'd1, 16'h0001, 16'h0110,
                   16'h0BAD, 1'b0);
        mem_access(1'b0, 16'h0202, 16'h0000, 16'h2468, 1, 4'd2, 1'b1, 2'd1, 16'h0002, 16'h0112,
                   16'h0200, 1'b0);
        tick();
        tick();

        // 4: load that is never acknowledged (TIMEOUT=8)
        in_valid = 1'b1;
        MemRead  = 1'b1;
        ALUOut   = 16'h0300;
        req_q.push_back('{1'b0, 16'h0300, 16'h0000});
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) chk("timeout_last_wait", {126'd0, err, stall}, 128'd1);
            tick();
        end
        @(negedge clk);
        chk("timeout_err", {125'd0, err, stall, mem_bus.mem_en}, 128'd6);
        tick();
        tick();
        @(negedge clk);
        chk("error_sticky", {126'd0, err, stall}, 128'd3);
        // Asynchronous reset in the middle of the low phase, load still presented
        #2 rst = 1'b0;
        #1;
        chk("async_reset_clears", {125'd0, err, stall, mem_bus.mem_en}, 128'd0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Pipeline works again after reset
        alu_op(16'h4321, 4'd9, 1'b1, 2'd2, 16'h0044, 16'h0200);
        tick();
        tick();

        chk("wb_queue_drained", 128'(wb_q.size()), 128'd0);
        chk("req_queue_drained", 128'(req_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
